// File: rtl/seq_multiplier_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier_if
// Description : Request/response bundle for seq_multiplier. The master side
//               issues start with operands a/b (and sgn in the signed build).
//               The slave side answers with busy, a one-cycle done pulse and
//               the held product p.
//               Optional feature macro: SEQ_MULT_SIGNED_EN (adds sgn).
//   Signals   : start (m->s)  request a multiply
//               a, b  (m->s)  WIDTH-bit multiplicand / multiplier
//               sgn   (m->s)  two's complement operands (signed build only)
//               busy  (s->m)  multiply in progress
//               done  (s->m)  one-cycle completion pulse
//               p     (s->m)  2*WIDTH-bit product register
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_multiplier_if #(
    parameter int WIDTH = 4
);
    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     p;
`ifdef SEQ_MULT_SIGNED_EN
    logic                   sgn;

    modport master (output start, a, b, sgn, input busy, done, p);
    modport slave  (input start, a, b, sgn, output busy, done, p);
`else
    modport master (output start, a, b, input busy, done, p);
    modport slave  (input start, a, b, output busy, done, p);
`endif
endinterface
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier
// Description : Sequential shift-add multiplier. One multiplier bit is
//               consumed per clock through a single WIDTH-bit adder, so a
//               product takes WIDTH cycles after start is accepted.
//               Optional feature macro: SEQ_MULT_SIGNED_EN (two's complement
//               operands selected per request by bus.sgn).
//   Ports     : clk  - system clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - seq_multiplier_if slave modport
//                      (start, a, b, [sgn] in; busy, done, p out)
//   Params    : WIDTH - operand width, 2..32; product is 2*WIDTH bits
// Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    seq_multiplier_if.slave     bus
);

    localparam int                c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       mcand_q, mcand_d;   // multiplicand (magnitude)
    logic [WIDTH-1:0]       mplr_q,  mplr_d;    // multiplier / low product half
    logic [WIDTH-1:0]       acc_q,   acc_d;     // high product half
    logic [c_cnt_w-1:0]     cnt_q,   cnt_d;
    logic [2*WIDTH-1:0]     p_q,     p_d;
    logic                   done_q,  done_d;

    logic [WIDTH-1:0]       w_addend;
    logic [WIDTH:0]         w_sum;
    logic [2*WIDTH-1:0]     w_prod;
    logic [2*WIDTH-1:0]     w_result;
    logic [WIDTH-1:0]       w_a_cap;
    logic [WIDTH-1:0]       w_b_cap;

    // Add step keeps the carry as bit WIDTH so nothing is lost before the
    // right shift folds it into the accumulator MSB.
    assign w_addend = mplr_q[0] ? mcand_q : '0;
    assign w_sum    = {1'b0, acc_q} + {1'b0, w_addend};

    // Product as it will stand after the current RUN edge's add-and-shift;
    // used at the final edge so p is loaded without an extra cycle.
    assign w_prod   = {w_sum, mplr_q[WIDTH-1:1]};

`ifdef SEQ_MULT_SIGNED_EN
    logic neg_q, neg_d;
    logic w_a_neg, w_b_neg;

    // Operate on magnitudes; -2^(WIDTH-1) negates to itself, which is the
    // correct unsigned magnitude in WIDTH bits.
    assign w_a_neg  = bus.sgn & bus.a[WIDTH-1];
    assign w_b_neg  = bus.sgn & bus.b[WIDTH-1];
    assign w_a_cap  = w_a_neg ? ({WIDTH{1'b0}} - bus.a) : bus.a;
    assign w_b_cap  = w_b_neg ? ({WIDTH{1'b0}} - bus.b) : bus.b;
    assign w_result = neg_q ? ({(2*WIDTH){1'b0}} - w_prod) : w_prod;
`else
    assign w_a_cap  = bus.a;
    assign w_b_cap  = bus.b;
    assign w_result = w_prod;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            done_q  <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            done_q  <= done_d;
`ifdef SEQ_MULT_SIGNED_EN
            neg_q   <= neg_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        done_d  = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
        neg_d   = neg_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    mcand_d = w_a_cap;
                    mplr_d  = w_b_cap;
                    acc_d   = '0;
                    cnt_d   = '0;
`ifdef SEQ_MULT_SIGNED_EN
                    neg_d   = w_a_neg ^ w_b_neg;
`endif
                end
            end

            S_RUN: begin
                // start is deliberately not looked at here: requests while
                // busy are dropped without disturbing the operation.
                acc_d  = w_sum[WIDTH:1];
                mplr_d = {w_sum[0], mplr_q[WIDTH-1:1]};
                cnt_d  = cnt_q + c_one;
                if (cnt_q == c_last) begin
                    state_d = S_IDLE;
                    p_d     = w_result;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = done_q;
    assign bus.p    = p_q;

endmodule
`default_nettype wire
